mem_wb_pipe_reg: RTL and testbench

//  Parametrised, clocked MEM/WB pipeline register with a valid/ready handshake, stall,

---
 rtl/mem_wb_pipe_reg.sv | 240 ++++++++++++++++++++++++
 tb/tb_mem_wb_pipe_reg.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_pipe_reg.sv
// MEM/WB pipeline register with a valid/ready handshake, stall and flush.
// It carries the WB control bits, memory read data, the ALU/immediate result
// and the destination register from MEM to WB. It also drives the
// forwarding-unit view of the WB-stage register write.
//
// Entry storage:
//   M - the main register. It always drives the outputs.
//   S - the skid register. It exists only when SKID != 0. S catches one extra
//       entry, so ready_o can come straight from a flop with no combinational
//       path from ready_i.
//
// Occupancy is held in a small state register:
//   EMPTY - no valid entry
//   FULL  - M valid
//   FULL2 - M and S valid (skid build only)
//
// Flush clears occupancy but leaves the data fields untouched. WB_o is gated
// by valid, so stale data never shows up as a register write.
module mem_wb_pipe_reg #(
    parameter int DATA_W = 32,
    parameter int WB_W   = 2,
    parameter int RA_W   = 5,
    parameter int SKID   = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              stall_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [WB_W-1:0]   WB_i,
    input  logic [DATA_W-1:0] ReadData_i,
    input  logic [DATA_W-1:0] immed_i,
    input  logic [RA_W-1:0]   mux3_i,
    input  logic              ready_i,
    output logic              valid_o,
    output logic [WB_W-1:0]   WB_o,
    output logic [DATA_W-1:0] ReadData_o,
    output logic [DATA_W-1:0] immed_o,
    output logic [RA_W-1:0]   mux3_o,
    output logic              fwd_we_o,
    output logic [RA_W-1:0]   fwd_rd_o
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_FULL  = 2'd1;
    localparam logic [1:0] ST_FULL2 = 2'd2;

    // Occupancy state
    logic [1:0]        state_q;
    logic [1:0]        state_d;

    // Main entry M
    logic [WB_W-1:0]   m_wb_q;
    logic [WB_W-1:0]   m_wb_d;
    logic [DATA_W-1:0] m_rdata_q;
    logic [DATA_W-1:0] m_rdata_d;
    logic [DATA_W-1:0] m_immed_q;
    logic [DATA_W-1:0] m_immed_d;
    logic [RA_W-1:0]   m_rd_q;
    logic [RA_W-1:0]   m_rd_d;

    // Skid entry S. These are tied to zero when SKID == 0.
    logic [WB_W-1:0]   s_wb_q;
    logic [DATA_W-1:0] s_rdata_q;
    logic [DATA_W-1:0] s_immed_q;
    logic [RA_W-1:0]   s_rd_q;

    // Handshake and load controls
    logic              m_valid;
    logic              stage_ready;
    logic              take;
    logic              give;
    logic              m_load_in;   // M captures the incoming entry
    logic              m_load_s;    // M captures the entry waiting in S
    logic              s_load_in;   // S captures the incoming entry

    assign m_valid = (state_q != ST_EMPTY);
    assign give    = m_valid & ready_i & ~stall_i;
    assign take    = valid_i & stage_ready;
    assign ready_o = stage_ready;

    if (SKID != 0) begin : g_skid

        logic [WB_W-1:0]   s_wb_d;
        logic [DATA_W-1:0] s_rdata_d;
        logic [DATA_W-1:0] s_immed_d;
        logic [RA_W-1:0]   s_rd_d;

        // ready_o depends only on state_q, so it is effectively a registered
        // signal: the stage stops accepting once S is occupied.
        assign stage_ready = (state_q != ST_FULL2);

        // Occupancy transitions and load selects for the two-entry version.
        always_comb begin
            state_d   = state_q;
            m_load_in = 1'b0;
            m_load_s  = 1'b0;
            s_load_in = 1'b0;
            if (flush_i) begin
                state_d = ST_EMPTY;
            end else begin
                case (state_q)
                    ST_EMPTY: begin
                        if (take) begin
                            state_d   = ST_FULL;
                            m_load_in = 1'b1;
                        end
                    end
                    ST_FULL: begin
                        if (take && give) begin
                            m_load_in = 1'b1;
                        end else if (take) begin
                            state_d   = ST_FULL2;
                            s_load_in = 1'b1;
                        end else if (give) begin
                            state_d = ST_EMPTY;
                        end
                    end
                    ST_FULL2: begin
                        // ready_o is low here, so only a give can happen.
                        if (give) begin
                            state_d  = ST_FULL;
                            m_load_s = 1'b1;
                        end
                    end
                    default: begin
                        state_d = ST_EMPTY;
                    end
                endcase
            end
        end

        // Next value of the skid entry: capture on s_load_in, otherwise hold.
        always_comb begin
            s_wb_d    = s_wb_q;
            s_rdata_d = s_rdata_q;
            s_immed_d = s_immed_q;
            s_rd_d    = s_rd_q;
            if (s_load_in) begin
                s_wb_d    = WB_i;
                s_rdata_d = ReadData_i;
                s_immed_d = immed_i;
                s_rd_d    = mux3_i;
            end
        end

        // Skid entry storage. Reset clears it immediately.
        always_ff @(posedge clk_i or negedge rst_i) begin
            if (!rst_i) begin
                s_wb_q    <= '0;
                s_rdata_q <= '0;
                s_immed_q <= '0;
                s_rd_q    <= '0;
            end else begin
                s_wb_q    <= s_wb_d;
                s_rdata_q <= s_rdata_d;
                s_immed_q <= s_immed_d;
                s_rd_q    <= s_rd_d;
            end
        end

    end else begin : g_no_skid

        // A single entry can accept while it is emptying in the same cycle.
        // This keeps full throughput, at the cost of a combinational ready path.
        assign stage_ready = ~m_valid | give;

        assign s_wb_q    = '0;
        assign s_rdata_q = '0;
        assign s_immed_q = '0;
        assign s_rd_q    = '0;

        // Occupancy transitions for the single-entry version.
        always_comb begin
            state_d   = state_q;
            m_load_in = 1'b0;
            m_load_s  = 1'b0;
            s_load_in = 1'b0;
            if (flush_i) begin
                state_d = ST_EMPTY;
            end else if (take) begin
                state_d   = ST_FULL;
                m_load_in = 1'b1;
            end else if (give) begin
                state_d = ST_EMPTY;
            end
        end

    end

    // Next value of the main entry: a new entry from upstream, or promotion
    // out of S. Otherwise it holds, including across a flush.
    always_comb begin
        m_wb_d    = m_wb_q;
        m_rdata_d = m_rdata_q;
        m_immed_d = m_immed_q;
        m_rd_d    = m_rd_q;
        if (m_load_in) begin
            m_wb_d    = WB_i;
            m_rdata_d = ReadData_i;
            m_immed_d = immed_i;
            m_rd_d    = mux3_i;
        end else if (m_load_s) begin
            m_wb_d    = s_wb_q;
            m_rdata_d = s_rdata_q;
            m_immed_d = s_immed_q;
            m_rd_d    = s_rd_q;
        end
    end

    // Occupancy and main entry storage. Reset drops everything at once.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= ST_EMPTY;
            m_wb_q    <= '0;
            m_rdata_q <= '0;
            m_immed_q <= '0;
            m_rd_q    <= '0;
        end else begin
            state_q   <= state_d;
            m_wb_q    <= m_wb_d;
            m_rdata_q <= m_rdata_d;
            m_immed_q <= m_immed_d;
            m_rd_q    <= m_rd_d;
        end
    end

    // An invalid entry never presents WB control, so RegWrite cannot leak out.
    assign valid_o    = m_valid;
    assign WB_o       = m_wb_q & {WB_W{m_valid}};
    assign ReadData_o = m_rdata_q;
    assign immed_o    = m_immed_q;
    assign mux3_o     = m_rd_q;

    // Register 0 is hard-wired, so a write to it is never worth forwarding.
    assign fwd_we_o = valid_o & WB_o[1] & (mux3_o != '0);
    assign fwd_rd_o = mux3_o;

endmodule

// File: tb/tb_mem_wb_pipe_reg.sv
// Testbench for mem_wb_pipe_reg.
// Two instances (SKID=0 and SKID=1) are driven with the same inputs. Each
// instance is compared against a queue model of capacity 1 or 2, plus a
// few directed scenarios with hand-computed expectations.
module tb_mem_wb_pipe_reg;

    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Shared inputs
    logic        rst_i;
    logic        flush_i;
    logic        stall_i;
    logic        valid_i;
    logic        ready_i;
    logic [1:0]  WB_i;
    logic [31:0] ReadData_i;
    logic [31:0] immed_i;
    logic [4:0]  mux3_i;

    // Outputs; index = SKID value of the instance
    logic        rdy_o [2];
    logic        vld_o [2];
    logic [1:0]  wb_o  [2];
    logic [31:0] rd_o  [2];
    logic [31:0] im_o  [2];
    logic [4:0]  ra_o  [2];
    logic        fwe_o [2];
    logic [4:0]  frd_o [2];

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        mem_wb_pipe_reg #(
            .DATA_W (32),
            .WB_W   (2),
            .RA_W   (5),
            .SKID   (gi)
        ) u_dut (
            .clk_i      (clk_i),
            .rst_i      (rst_i),
            .flush_i    (flush_i),
            .stall_i    (stall_i),
            .valid_i    (valid_i),
            .ready_o    (rdy_o[gi]),
            .WB_i       (WB_i),
            .ReadData_i (ReadData_i),
            .immed_i    (immed_i),
            .mux3_i     (mux3_i),
            .ready_i    (ready_i),
            .valid_o    (vld_o[gi]),
            .WB_o       (wb_o[gi]),
            .ReadData_o (rd_o[gi]),
            .immed_o    (im_o[gi]),
            .mux3_o     (ra_o[gi]),
            .fwd_we_o   (fwe_o[gi]),
            .fwd_rd_o   (frd_o[gi])
        );
    end

    int vectors     = 0;
    int miscompares = 0;

    // Behavioural model: an in-order queue per instance. mshow holds the data
    // currently on the output fields; it is the head entry, or the last shown
    // entry once the queue has drained.
    typedef struct packed {
        logic [1:0]  wb;
        logic [31:0] rd;
        logic [31:0] im;
        logic [4:0]  ra;
    } ent_t;

    ent_t mq    [2][2];
    int   mcnt  [2];
    ent_t mshow [2];

    function automatic bit exp_ready(input int k);
        if (k == 1) return (mcnt[1] < 2);
        return (mcnt[0] == 0) || (ready_i && !stall_i);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mcnt[k]  = 0;
            mshow[k] = '0;
        end
    endtask

    task automatic model_edge();
        bit   tk;
        bit   gv;
        ent_t e;
        e.wb = WB_i;
        e.rd = ReadData_i;
        e.im = immed_i;
        e.ra = mux3_i;
        for (int k = 0; k < 2; k++) begin
            tk = valid_i && exp_ready(k);
            gv = (mcnt[k] > 0) && ready_i && !stall_i;
            if (flush_i) begin
                mcnt[k] = 0;
            end else begin
                if (gv) begin
                    mq[k][0] = mq[k][1];
                    mcnt[k]--;
                end
                if (tk) begin
                    mq[k][mcnt[k]] = e;
                    mcnt[k]++;
                end
            end
            if (mcnt[k] > 0) mshow[k] = mq[k][0];
        end
    endtask

    task automatic chk(input string nm, input int k, input logic [63:0] act,
                       input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s skid=%0d t=%0t got=%0h expected=%0h", nm, k, $time, act, exp);
        end
    endtask

    task automatic check_all();
        logic       v;
        logic [1:0] w;
        for (int k = 0; k < 2; k++) begin
            v = (mcnt[k] > 0);
            w = v ? mshow[k].wb : 2'b00;
            chk("valid_o",    k, vld_o[k], v);
            chk("WB_o",       k, wb_o[k],  w);
            chk("ReadData_o", k, rd_o[k],  mshow[k].rd);
            chk("immed_o",    k, im_o[k],  mshow[k].im);
            chk("mux3_o",     k, ra_o[k],  mshow[k].ra);
            chk("fwd_we_o",   k, fwe_o[k], v && w[1] && (mshow[k].ra != 5'd0));
            chk("fwd_rd_o",   k, frd_o[k], mshow[k].ra);
            if (rst_i) chk("ready_o", k, rdy_o[k], exp_ready(k));
        end
    endtask

    task automatic set_in(input logic v, input logic [1:0] wb, input logic [31:0] rd,
                          input logic [31:0] im, input logic [4:0] ra,
                          input logic rdy, input logic stl, input logic fl);
        valid_i    = v;
        WB_i       = wb;
        ReadData_i = rd;
        immed_i    = im;
        mux3_i     = ra;
        ready_i    = rdy;
        stall_i    = stl;
        flush_i    = fl;
    endtask

    // Check against the model, advance one clock edge, then move just past it.
    task automatic step();
        #1;
        check_all();
        @(posedge clk_i);
        model_edge();
        #1;
    endtask

    initial begin
        // Reset held low while upstream presents a valid entry
        rst_i = 1'b0;
        set_in(1'b1, 2'b11, 32'hDEADBEEF, 32'h1, 5'd7, 1'b1, 1'b0, 1'b0);
        model_reset();
        #12;
        for (int k = 0; k < 2; k++) begin
            chk("rst_valid_o",  k, vld_o[k], 0);
            chk("rst_WB_o",     k, wb_o[k],  0);
            chk("rst_ReadData", k, rd_o[k],  0);
            chk("rst_fwd_we",   k, fwe_o[k], 0);
        end
        check_all();
        rst_i = 1'b1;
        set_in(1'b0, 2'b00, 32'h0, 32'h0, 5'd0, 1'b1, 1'b0, 1'b0);
        #1;
        chk("rel_ready_o", 1, rdy_o[1], 1);
        chk("rel_ready_o", 0, rdy_o[0], 1);

        // Single entry with RegWrite to r7
        set_in(1'b1, 2'b11, 32'hDEADBEEF, 32'h0000_1234, 5'd7, 1'b1, 1'b0, 1'b0);
        step();
        set_in(1'b0, 2'b00, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("t2_valid_o",  1, vld_o[1], 1);
        chk("t2_ReadData", 1, rd_o[1],  32'hDEADBEEF);
        chk("t2_fwd_we",   1, fwe_o[1], 1);
        chk("t2_fwd_rd",   1, frd_o[1], 7);
        set_in(1'b0, 2'b00, 32'h0, 32'h0, 5'd0, 1'b1, 1'b0, 1'b0);
        step();

        // Back-to-back A, B into a blocked downstream, then drain in order
        set_in(1'b1, 2'b10, 32'hAAAA_0001, 32'h11, 5'd3, 1'b0, 1'b0, 1'b0);
        step();
        set_in(1'b1, 2'b01, 32'hBBBB_0002, 32'h22, 5'd4, 1'b0, 1'b0, 1'b0);
        step();
        set_in(1'b0, 2'b00, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("t3_ready_full2", 1, rdy_o[1], 0);
        chk("t3_hold_A",      1, rd_o[1],  32'hAAAA_0001);
        step();
        ready_i = 1'b1;
        #1;
        chk("t3_give_A", 1, rd_o[1], 32'hAAAA_0001);
        step();
        #1;
        chk("t3_give_B",    1, rd_o[1], 32'hBBBB_0002);
        chk("t3_B_valid",   1, vld_o[1], 1);
        step();
        #1;
        chk("t3_drained", 1, vld_o[1], 0);

        // Stall holds the output entry even with ready_i high
        set_in(1'b1, 2'b11, 32'hC0DE_0004, 32'h44, 5'd9, 1'b1, 1'b0, 1'b0);
        step();
        set_in(1'b0, 2'b00, 32'h0, 32'h0, 5'd0, 1'b1, 1'b1, 1'b0);
        step();
        step();
        #1;
        chk("t4_stall_valid", 1, vld_o[1], 1);
        chk("t4_stall_data",  1, rd_o[1],  32'hC0DE_0004);
        stall_i = 1'b0;
        step();
        #1;
        chk("t4_given", 1, vld_o[1], 0);

        // Flush while FULL2 with a valid entry arriving
        set_in(1'b1, 2'b11, 32'h1111_0005, 32'h55, 5'd5, 1'b0, 1'b0, 1'b0);
        step();
        set_in(1'b1, 2'b11, 32'h2222_0006, 32'h66, 5'd6, 1'b0, 1'b0, 1'b0);
        step();
        set_in(1'b1, 2'b11, 32'h3333_0007, 32'h77, 5'd8, 1'b0, 1'b0, 1'b1);
        step();
        set_in(1'b0, 2'b00, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("t5_valid_o", 1, vld_o[1], 0);
        chk("t5_WB_o",    1, wb_o[1],  0);
        chk("t5_ready_o", 1, rdy_o[1], 1);
        step();

        // RegWrite to r0 is not forwarded
        set_in(1'b1, 2'b10, 32'h0BAD_0000, 32'h99, 5'd0, 1'b0, 1'b0, 1'b0);
        step();
        set_in(1'b0, 2'b00, 32'h0, 32'h0, 5'd0, 1'b1, 1'b0, 1'b0);
        #1;
        chk("t6_valid_o", 1, vld_o[1], 1);
        chk("t6_WB_o",    1, wb_o[1],  2'b10);
        chk("t6_fwd_we",  1, fwe_o[1], 0);
        step();

        // Random traffic, with one asynchronous reset pulse mid-run
        for (int i = 0; i < 1500; i++) begin
            set_in($urandom_range(0, 3) != 0,
                   2'($urandom_range(0, 3)),
                   $urandom, $urandom,
                   ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                   $urandom_range(0, 3) != 0,
                   $urandom_range(0, 3) == 0,
                   $urandom_range(0, 15) == 0);
            if (i == 700) begin
                rst_i = 1'b0;
                #1;
                model_reset();
                check_all();
                rst_i = 1'b1;
            end
            step();
        end
        #1;
        check_all();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
